// File: rtl/cla_pkg.sv
// Shared types and helpers for the carry-lookahead word sequencer.
package cla_pkg;

    localparam int unsigned CLA_W = 8;

    typedef enum logic {
        IDLE    = 1'b0,
        IN_WORD = 1'b1
    } state_t;

    // One registered output beat.
    typedef struct packed {
        logic [CLA_W-1:0] sum;
        logic             last;
        logic             carry;
        logic             ovf;
        logic             zero;
    } out_beat_t;

    // Two's-complement overflow from the MSBs of the addend pair and the sum.
    function automatic logic signed_ovf(
        input logic a_msb,
        input logic b_msb,
        input logic s_msb
    );
        return (a_msb == b_msb) && (s_msb != a_msb);
    endfunction

endpackage

// File: rtl/cla8_core.sv
// Combinational 8-bit carry-lookahead adder with carry-in and carry-out.
module cla8_core
    import cla_pkg::*;
(
    input  logic [CLA_W-1:0] i_a,
    input  logic [CLA_W-1:0] i_b,
    input  logic             i_cin,
    output logic [CLA_W-1:0] o_sum,
    output logic             o_cout
);

    logic [CLA_W-1:0] w_g;
    logic [CLA_W-1:0] w_p;
    logic [CLA_W:0]   w_c;
    logic             w_term;
    logic             w_acc;

    assign w_g = i_a & i_b;
    assign w_p = i_a ^ i_b;

    // Each carry is the flat OR of generate terms gated by every propagate above them.
    always_comb begin
        w_c    = '0;
        w_term = 1'b0;
        w_acc  = 1'b0;
        w_c[0] = i_cin;
        for (int i = 0; i < CLA_W; i++) begin
            w_term = i_cin;
            for (int m = 0; m <= i; m++) begin
                w_term = w_term & w_p[m];
            end
            w_acc = w_term;
            for (int k = 0; k <= i; k++) begin
                w_term = w_g[k];
                for (int m = k + 1; m <= i; m++) begin
                    w_term = w_term & w_p[m];
                end
                w_acc = w_acc | w_term;
            end
            w_c[i+1] = w_acc;
        end
    end

    assign o_sum  = w_p ^ w_c[CLA_W-1:0];
    assign o_cout = w_c[CLA_W];

endmodule

// File: rtl/cla_word_sequencer.sv
// Byte-serial multi-byte add/sub sequencer around an 8-bit CLA, LSB first,
// with carry chained between beats and word-level carry/overflow/zero flags.
module cla_word_sequencer
    import cla_pkg::*;
#(
    parameter int unsigned WORD_BYTES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr_err,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_first,
    input  logic             in_last,
    input  logic             in_sub,
    input  logic [CLA_W-1:0] a_byte,
    input  logic [CLA_W-1:0] b_byte,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CLA_W-1:0] sum_byte,
    output logic             out_last,
    output logic             out_carry,
    output logic             out_ovf,
    output logic             out_zero,
    output logic             err
);

    localparam int unsigned CNT_W = $clog2(WORD_BYTES + 1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic             r_carry;
    logic             r_sub;
    logic             r_zero;
    logic [CNT_W-1:0] r_cnt;
    out_beat_t        r_out;
    logic             r_out_valid;
    logic             r_err;

    logic             w_accept;
    logic             w_first;
    logic             w_sub;
    logic             w_cin;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_cnt_full;
    logic             w_end;
    logic             w_err_set;
    logic [CLA_W-1:0] w_b_eff;
    logic [CLA_W-1:0] w_sum;
    logic             w_cout;
    logic             w_zero_acc;
    logic             w_ovf;

    assign in_ready = !r_out_valid | out_ready;
    assign w_accept = in_valid & in_ready;

    // Next-state, beat framing and carry-in selection.
    always_comb begin
        w_state_nxt = r_state;
        w_first     = 1'b0;
        w_sub       = r_sub;
        w_cin       = r_carry;
        w_cnt_nxt   = r_cnt;
        w_cnt_full  = 1'b0;
        w_end       = 1'b0;
        w_err_set   = 1'b0;

        // A beat in IDLE always opens a word; in_first mid-word restarts it.
        w_first    = (r_state == IDLE) | in_first;
        w_sub      = w_first ? in_sub : r_sub;
        w_cin      = w_first ? in_sub : r_carry;
        w_cnt_nxt  = w_first ? CNT_W'(1) : r_cnt + CNT_W'(1);
        w_cnt_full = (w_cnt_nxt == CNT_W'(WORD_BYTES));
        w_end      = in_last | w_cnt_full;

        w_err_set = w_accept & (((r_state == IDLE) & !in_first) |
                                ((r_state == IN_WORD) & in_first) |
                                (w_cnt_full & !in_last));

        case (r_state)
            IDLE: begin
                if (w_accept && !w_end) begin
                    w_state_nxt = IN_WORD;
                end
            end
            IN_WORD: begin
                if (w_accept && w_end) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    assign w_b_eff = w_sub ? ~b_byte : b_byte;

    cla8_core u_cla (
        .i_a    (a_byte),
        .i_b    (w_b_eff),
        .i_cin  (w_cin),
        .o_sum  (w_sum),
        .o_cout (w_cout)
    );

    assign w_zero_acc = (w_first | r_zero) & (w_sum == '0);
    assign w_ovf      = signed_ovf(a_byte[CLA_W-1], w_b_eff[CLA_W-1], w_sum[CLA_W-1]);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Per-word context: chained carry, latched op, beat count, running zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_carry <= 1'b0;
            r_sub   <= 1'b0;
            r_zero  <= 1'b1;
            r_cnt   <= '0;
        end else if (w_accept) begin
            r_carry <= w_cout;
            r_sub   <= w_sub;
            if (w_end) begin
                r_cnt  <= '0;
                r_zero <= 1'b1;
            end else begin
                r_cnt  <= w_cnt_nxt;
                r_zero <= w_zero_acc;
            end
        end
    end

    // Single output register; holds while stalled, word flags only on the last beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out       <= '0;
        end else if (w_accept) begin
            r_out_valid <= 1'b1;
            r_out.sum   <= w_sum;
            r_out.last  <= w_end;
            r_out.carry <= w_end & w_cout;
            r_out.ovf   <= w_end & w_ovf;
            r_out.zero  <= w_end & w_zero_acc;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    // Sticky framing error; a new violation beats a same-cycle clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err <= 1'b0;
        end else if (w_err_set) begin
            r_err <= 1'b1;
        end else if (clr_err) begin
            r_err <= 1'b0;
        end
    end

    assign out_valid = r_out_valid;
    assign sum_byte  = r_out.sum;
    assign out_last  = r_out.last;
    assign out_carry = r_out.carry;
    assign out_ovf   = r_out.ovf;
    assign out_zero  = r_out.zero;
    assign err       = r_err;

endmodule
